// File: rtl/aes_round_sequencer_pkg.sv
// rtl/aes_round_sequencer_pkg.sv - shared AES sequencer types, block width and round-count helper
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  // Rounds required for a given key length in 32-bit words; 0 flags an illegal key length.
  function automatic int nr_for_nk(input int nk);
    case (nk)
      4:       return 10;
      6:       return 12;
      8:       return 14;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - block stream, key-schedule and round-datapath signals of the sequencer
interface aes_round_sequencer_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_data;
  logic [3:0]             rk_idx;
  logic [AES_BLOCK_W-1:0] rk_data;
  logic [AES_BLOCK_W-1:0] dp_state;
  logic                   dp_final;
  logic [AES_BLOCK_W-1:0] dp_result;

  // Sequencer side: consumes blocks, round keys and round results.
  modport master (
    input  in_valid, in_data, out_ready, rk_data, dp_result,
    output in_ready, out_valid, out_data, rk_idx, dp_state, dp_final
  );

  // Environment side: block source/sink, key schedule and round datapath.
  modport slave (
    output in_valid, in_data, out_ready, rk_data, dp_result,
    input  in_ready, out_valid, out_data, rk_idx, dp_state, dp_final
  );

endinterface

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES round controller; optional abort port under AES_SEQ_ABORT_EN
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_round_sequencer_if.master bus
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  // Reject key-length / round-count combinations that are not AES.
  if (NR != nr_for_nk(NK)) begin : g_bad_cfg
    $error("aes_round_sequencer: NR does not match NK");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  seq_state_e             state_q;
  seq_state_e             state_d;
  logic [3:0]             rnd_q;
  logic [AES_BLOCK_W-1:0] st_q;
  logic                   kill;
  logic                   last_rnd;

`ifdef AES_SEQ_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign last_rnd = (rnd_q == NR_L);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and registered-state output decodes; abort overrides every transition.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_idx    = 4'd0;
    bus.dp_final  = 1'b0;
    bus.dp_state  = st_q;
    bus.out_data  = st_q;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = ROUND;
      end
      ROUND: begin
        bus.rk_idx   = rnd_q;
        bus.dp_final = last_rnd;
        if (last_rnd) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Cipher state and round counter: whitening on accept, datapath feedback each round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      rnd_q <= 4'd0;
    end else if (kill) begin
      st_q  <= '0;
      rnd_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            st_q  <= bus.in_data ^ bus.rk_data;
            rnd_q <= 4'd1;
          end
        end
        ROUND: begin
          st_q <= bus.dp_result;
          if (!last_rnd) rnd_q <= rnd_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed FIPS-197 vectors against the sequencer with a reference round datapath
module tb_aes_round_sequencer;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [255:0] KEY4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   emit4 = 0;
  int   acc4 [$];
  logic [127:0] outs4 [$];
  logic [127:0] rk4 [0:15];
  logic [127:0] rk8 [0:15];
`ifdef AES_SEQ_ABORT_EN
  logic abort;
`endif

  aes_round_sequencer_if b4 ();
  aes_round_sequencer_if b8 ();

  aes_round_sequencer #(.NK(4), .NR(10)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
`ifdef AES_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  aes_round_sequencer #(.NK(8), .NR(14)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
`ifdef AES_SEQ_ABORT_EN
    , .abort(1'b0)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4*(r+1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int j = 1; j < i/nk; j++) rc = xt(rc);
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m [4];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[4*c+rr] = a[4*((c+rr)%4)+rr];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        m[0] = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        m[1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        m[2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        m[3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
        for (int rr = 0; rr < 4; rr++) b[4*c+rr] = m[rr];
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  assign b4.rk_data   = rk4[b4.rk_idx];
  assign b4.dp_result = aes_round(b4.dp_state, b4.rk_data, b4.dp_final);
  assign b8.rk_data   = rk8[b8.rk_idx];
  assign b8.dp_result = aes_round(b8.dp_state, b8.rk_data, b8.dp_final);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b4.in_valid && b4.in_ready) acc4.push_back(cyc);
    if (b4.out_valid && b4.out_ready) begin
      emit4 <= emit4 + 1;
      outs4.push_back(b4.out_data);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept4(input logic [127:0] pt);
    b4.in_data  = pt;
    b4.in_valid = 1'b1;
    check("in_ready_idle", b4.in_ready, 1);
    check("rk_idx_idle", b4.rk_idx, 0);
    tick();
    b4.in_valid = 1'b0;
  endtask

  task automatic finish4(input logic [127:0] exp);
    int lat = 0;
    while (b4.out_valid !== 1'b1 && lat < 40) begin
      check("rk_idx_seq", b4.rk_idx, lat + 1);
      check("dp_final_seq", b4.dp_final, (lat + 1 == 10));
      tick();
      lat++;
    end
    check("latency_nr10", lat, 10);
    check("out_data_c1", b4.out_data, exp);
    check("in_ready_done", b4.in_ready, 0);
    check("rk_idx_done", b4.rk_idx, 0);
  endtask

  initial begin
    int base;
    int guard;
    int lat;
    for (int i = 0; i < 16; i++) begin
      rk4[i] = (i <= 10) ? round_key(KEY4, 4, i) : 128'h0;
      rk8[i] = (i <= 14) ? round_key(KEY8, 8, i) : 128'h0;
    end
    rst_n = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    check("rst_in_ready", b4.in_ready, 1);
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_out_data", b4.out_data, 0);
    check("rst_rk_idx", b4.rk_idx, 0);
    check("rst_dp_final", b4.dp_final, 0);
    check("rst_dp_state", b4.dp_state, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1, left waiting in DONE for the backpressure step
    accept4(PT);
    finish4(CT4);

    // Backpressure with a second block already offered
    base = acc4.size();
    b4.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", b4.out_valid, 1);
      check("bp_out_data", b4.out_data, CT4);
      check("bp_in_ready", b4.in_ready, 0);
      tick();
    end
    check("bp_no_accept", acc4.size(), base);
    b4.out_ready = 1'b1;
    tick();
    b4.out_ready = 1'b0;
    check("bp_emit", emit4, 1);
    check("bp_emit_data", outs4[0], CT4);
    check("bp_idle_out_valid", b4.out_valid, 0);
    check("bp_idle_in_ready", b4.in_ready, 1);
    tick();
    b4.in_valid = 1'b0;
    check("bp_accept_next", acc4.size(), base + 1);
    check("bp_round1", b4.rk_idx, 1);
    finish4(CT4);
    b4.out_ready = 1'b1;
    tick();
    b4.out_ready = 1'b0;

    // Back-to-back: three blocks with both handshakes held high
    acc4.delete();
    outs4.delete();
    base = emit4;
    guard = 0;
    b4.in_data = PT;
    b4.in_valid = 1'b1;
    b4.out_ready = 1'b1;
    while (emit4 < base + 3 && guard < 100) begin
      tick();
      guard++;
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b0;
    check("b2b_timeout", guard < 100, 1);
    check("b2b_accepts", acc4.size(), 3);
    check("b2b_gap01", acc4[1] - acc4[0], 12);
    check("b2b_gap12", acc4[2] - acc4[1], 12);
    for (int i = 0; i < 3; i++) check("b2b_ct", outs4[i], CT4);

    // Reset while rnd=5 discards the block
    accept4(PT);
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_rnd5", b4.rk_idx, 5);
    base = emit4;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", b4.out_valid, 0);
    check("mid_rst_in_ready", b4.in_ready, 1);
    check("mid_rst_rk_idx", b4.rk_idx, 0);
    check("mid_rst_dp_state", b4.dp_state, 0);
    tick();
    rst_n = 1'b1;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("mid_rst_no_emit", emit4, base);
    b4.out_ready = 1'b0;
    accept4(PT);
    finish4(CT4);
    b4.out_ready = 1'b1;
    tick();
    b4.out_ready = 1'b0;

    // FIPS-197 C.3 on the 256-bit-key instance
    b8.in_data = PT;
    b8.in_valid = 1'b1;
    check("c3_in_ready", b8.in_ready, 1);
    tick();
    b8.in_valid = 1'b0;
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check("c3_latency", lat, 14);
    check("c3_out_data", b8.out_data, CT8);
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    check("c3_idle", b8.in_ready, 1);

`ifdef AES_SEQ_ABORT_EN
    // Abort mid-block and abort racing an offered block
    base = emit4;
    accept4(PT);
    tick();
    tick();
    check("abort_at_rnd3", b4.rk_idx, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", b4.in_ready, 1);
    check("abort_out_valid", b4.out_valid, 0);
    check("abort_dp_state", b4.dp_state, 0);
    abort = 1'b1;
    b4.in_valid = 1'b1;
    tick();
    abort = 1'b0;
    b4.in_valid = 1'b0;
    check("abort_no_accept", b4.in_ready, 1);
    check("abort_no_accept_rk", b4.rk_idx, 0);
    b4.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    b4.out_ready = 1'b0;
    check("abort_no_emit", emit4, base);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
